array_ctrl: RTL and testbench

Sequencer for the HEIGHT×WIDTH weight-stationary systolic array. It accepts one job (a count of input vectors), then:

- clears the array's input, weight and output registers;
- loads one weight tile;
- streams the input vectors with per-row skew;
- collects outputs with per-column skew.

It sits between the tile-level buffer/DMA logic and the array. It drives every `en_*` and `clr_*` lane of the array and hands ready/valid strobes to the buffers.

---
 rtl/array_pkg.sv | 18 +
 rtl/lane_window.sv | 21 ++
 rtl/array_ctrl.sv | 142 ++++++++++++++
 tb/tb_array_ctrl.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/array_pkg.sv
// Shared types and default geometry for the systolic-array sequencer.
package array_pkg;

   localparam int DEF_HEIGHT = 12;
   localparam int DEF_WIDTH  = 14;
   localparam int DEF_CWIDTH = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      CLEAR  = 3'd1,
      WLOAD  = 3'd2,
      STREAM = 3'd3,
      DONE   = 3'd4
   } state_e;

   typedef logic [DEF_CWIDTH-1:0] cnt_t;

endpackage

// File: rtl/lane_window.sv
// One lane's activity window: high while OFFSET <= t < OFFSET+n_vec.
module lane_window #(
   parameter int CWIDTH = array_pkg::DEF_CWIDTH,
   parameter int OFFSET = 0
) (
   input  logic [CWIDTH:0]   t,
   input  logic [CWIDTH-1:0] n_vec,
   output logic              hit
);

   // One extra bit of headroom so OFFSET+n_vec never wraps.
   logic [CWIDTH+1:0] w_t;
   logic [CWIDTH+1:0] w_lo;
   logic [CWIDTH+1:0] w_hi;

   assign w_t  = {1'b0, t};
   assign w_lo = (CWIDTH+2)'(OFFSET);
   assign w_hi = w_lo + {2'b00, n_vec};
   assign hit  = (w_t >= w_lo) && (w_t < w_hi);

endmodule

// File: rtl/array_ctrl.sv
// Sequencer for a HEIGHT x WIDTH weight-stationary systolic array.
// Optional ARRAY_CTRL_STALL_EN adds a stall input that freezes WLOAD/STREAM.
module array_ctrl
   import array_pkg::*;
#(
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int WIDTH  = DEF_WIDTH,
   parameter int CWIDTH = DEF_CWIDTH
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [CWIDTH-1:0] n_vec,
   input  logic              abort,
`ifdef ARRAY_CTRL_STALL_EN
   input  logic              stall,
`endif
   output logic              busy,
   output logic              done,
   output logic              wght_rdy,
   output logic              ifm_rdy,
   output logic              ofm_vld,
   output logic [HEIGHT-1:0] en_i,
   output logic [HEIGHT-1:0] clr_i,
   output logic [WIDTH-1:0]  en_w,
   output logic [WIDTH-1:0]  clr_w,
   output logic [WIDTH-1:0]  en_o,
   output logic [WIDTH-1:0]  clr_o
);

   state_e            r_state;
   logic [CWIDTH:0]   r_cnt;
   logic [CWIDTH-1:0] r_nvec;

   logic              w_stall;
   logic [CWIDTH:0]   w_last;
   logic              w_clr;
   logic              w_wld;
   logic              w_str;
   logic [HEIGHT-1:0] w_hit_i;
   logic [WIDTH-1:0]  w_hit_o;

`ifdef ARRAY_CTRL_STALL_EN
   assign w_stall = stall && ((r_state == WLOAD) || (r_state == STREAM));
`else
   assign w_stall = 1'b0;
`endif

   // Final STREAM index: L-1 = n_vec + HEIGHT + WIDTH - 2.
   assign w_last = {1'b0, r_nvec} + (CWIDTH+1)'(HEIGHT + WIDTH - 2);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_nvec  <= '0;
      end else if (abort) begin
         r_state <= IDLE;
         r_cnt   <= '0;
      end else begin
         unique case (r_state)
            IDLE: begin
               r_cnt <= '0;
               if (start) begin
                  if (n_vec != '0) begin
                     r_state <= CLEAR;
                     r_nvec  <= n_vec;
                  end else begin
                     r_state <= DONE;
                  end
               end
            end
            CLEAR: begin
               r_state <= WLOAD;
               r_cnt   <= '0;
            end
            WLOAD: begin
               if (!w_stall) begin
                  if (r_cnt == (CWIDTH+1)'(HEIGHT - 1)) begin
                     r_state <= STREAM;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            STREAM: begin
               if (!w_stall) begin
                  if (r_cnt == w_last) begin
                     r_state <= DONE;
                     r_cnt   <= '0;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
            end
            DONE: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
            default: begin
               r_state <= IDLE;
               r_cnt   <= '0;
            end
         endcase
      end
   end

   // Row h sees vector j at t = h + j; column w drains it HEIGHT cycles later.
   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      lane_window #(.CWIDTH(CWIDTH), .OFFSET(h)) u_win (
         .t     (r_cnt),
         .n_vec (r_nvec),
         .hit   (w_hit_i[h])
      );
   end

   for (genvar w = 0; w < WIDTH; w++) begin : g_col
      lane_window #(.CWIDTH(CWIDTH), .OFFSET(w + HEIGHT)) u_win (
         .t     (r_cnt),
         .n_vec (r_nvec),
         .hit   (w_hit_o[w])
      );
   end

   assign w_clr = (r_state == CLEAR);
   assign w_wld = (r_state == WLOAD)  && !w_stall;
   assign w_str = (r_state == STREAM) && !w_stall;

   assign busy     = (r_state == CLEAR) || (r_state == WLOAD) || (r_state == STREAM);
   assign done     = (r_state == DONE);
   assign clr_i    = {HEIGHT{w_clr}};
   assign clr_w    = {WIDTH{w_clr}};
   assign clr_o    = {WIDTH{w_clr}};
   assign en_w     = {WIDTH{w_wld}};
   assign wght_rdy = w_wld;
   assign en_i     = w_hit_i & {HEIGHT{w_str}};
   assign en_o     = w_hit_o & {WIDTH{w_str}};
   assign ifm_rdy  = w_str && (r_cnt < {1'b0, r_nvec});
   assign ofm_vld  = |en_o;

endmodule

// File: tb/tb_array_ctrl.sv
// Bench for array_ctrl: step-based job model plus directed schedule checks.
module tb_array_ctrl;
   import array_pkg::*;

   localparam int H  = 12;
   localparam int W  = 14;
   localparam int CW = 16;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         start = 1'b0;
   logic         abort = 1'b0;
   logic         stall = 1'b0;
   cnt_t         n_vec = '0;
   logic         busy, done, wght_rdy, ifm_rdy, ofm_vld;
   logic [H-1:0] en_i, clr_i;
   logic [W-1:0] en_w, clr_w, en_o, clr_o;

   always #5 clk = ~clk;

   array_ctrl #(.HEIGHT(H), .WIDTH(W), .CWIDTH(CW)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .n_vec    (n_vec),
      .abort    (abort),
`ifdef ARRAY_CTRL_STALL_EN
      .stall    (stall),
`endif
      .busy     (busy),
      .done     (done),
      .wght_rdy (wght_rdy),
      .ifm_rdy  (ifm_rdy),
      .ofm_vld  (ofm_vld),
      .en_i     (en_i),
      .clr_i    (clr_i),
      .en_w     (en_w),
      .clr_w    (clr_w),
      .en_o     (en_o),
      .clr_o    (clr_o)
   );

   int n_chk  = 0;
   int n_fail = 0;
   int cyc    = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Job model: step s counts progress since acceptance.
   // s=0 CLEAR, 1..H WLOAD, H+1..H+L STREAM, s==tot DONE (tot=0 for empty jobs).
   bit m_job = 0;
   int m_s = 0, m_n = 0, m_tot = 0;

   task automatic check_all();
      int           len, t;
      bit           in_wl, in_st, run;
      logic [H-1:0] ei;
      logic [W-1:0] eo;
      len   = m_n + H + W - 1;
      in_wl = m_job && m_tot > 0 && m_s >= 1 && m_s <= H;
      in_st = m_job && m_tot > 0 && m_s >= H + 1 && m_s <= H + len;
      run   = !stall;
      t     = m_s - H - 1;
      ei = '0;
      eo = '0;
      for (int h = 0; h < H; h++) ei[h] = in_st && run && t >= h && t < h + m_n;
      for (int w = 0; w < W; w++) eo[w] = in_st && run && t >= w + H && t < w + H + m_n;
      chk("busy",     busy,     m_job && m_s < m_tot);
      chk("done",     done,     m_job && m_s == m_tot);
      chk("clr_i",    clr_i,    {H{m_job && m_tot > 0 && m_s == 0}});
      chk("clr_w",    clr_w,    {W{m_job && m_tot > 0 && m_s == 0}});
      chk("clr_o",    clr_o,    {W{m_job && m_tot > 0 && m_s == 0}});
      chk("en_w",     en_w,     {W{in_wl && run}});
      chk("wght_rdy", wght_rdy, in_wl && run);
      chk("en_i",     en_i,     ei);
      chk("en_o",     en_o,     eo);
      chk("ifm_rdy",  ifm_rdy,  in_st && run && t < m_n);
      chk("ofm_vld",  ofm_vld,  |eo);
   endtask

   task automatic model_upd();
      if (abort) begin
         m_job = 0;
      end else if (!m_job) begin
         if (start) begin
            m_job = 1;
            m_s   = 0;
            m_n   = int'(n_vec);
            m_tot = (m_n == 0) ? 0 : 2 * H + W + m_n;
         end
      end else if (m_s == m_tot) begin
         m_job = 0;
      end else if (!(stall && m_s >= 1 && m_s < m_tot)) begin
         m_s++;
      end
   endtask

   // Inputs are set at the negedge; check, then clock, then update the model.
   task automatic step();
      check_all();
      @(posedge clk);
      model_upd();
      cyc++;
      @(negedge clk);
   endtask

   task automatic start_job(input int n, output int k);
      start = 1'b1;
      n_vec = cnt_t'(n);
      k     = cyc;
      step();
      start = 1'b0;
   endtask

   int k, d, e11, o13, c1, d1, c2, pat, o;

   initial begin
      repeat (2) @(negedge clk);
      check_all();
      chk("reset_busy", busy, 1'b0);
      rst_n = 1'b1;
      step();

      // Nominal job, absolute offsets from the acceptance cycle.
      start_job(4, k);
      d = -1; e11 = -1; o13 = -1; c1 = -1;
      for (int i = 0; i < 200 && d < 0; i++) begin
         if (clr_i === {H{1'b1}} && c1 < 0) c1 = cyc - k;
         if (en_i[H-1] === 1'b1 && e11 < 0) e11 = cyc - k;
         if (en_o[W-1] === 1'b1 && o13 < 0) o13 = cyc - k;
         if (done === 1'b1) d = cyc - k;
         step();
      end
      chk("nom_clr_at", 64'(c1), 64'd1);
      chk("nom_eni11_at", 64'(e11), 64'd25);
      chk("nom_eno13_at", 64'(o13), 64'd39);
      chk("nom_done_at", 64'(d), 64'd43);
      step();

      // Empty job completes straight away.
      start_job(0, k);
      chk("zero_done", done, 1'b1);
      chk("zero_busy", busy, 1'b0);
      step();

      // Back-to-back with start held high.
      start = 1'b1; n_vec = 2; k = cyc;
      d1 = -1; c2 = -1;
      for (int i = 0; i < 300 && c2 < 0; i++) begin
         if (done === 1'b1 && d1 < 0) d1 = cyc;
         if (d1 >= 0 && cyc > d1 && clr_i === {H{1'b1}}) c2 = cyc;
         step();
      end
      start = 1'b0;
      chk("b2b_gap", 64'(c2 - d1), 64'd2);
      abort = 1'b1; step(); abort = 1'b0;

      // Abort at STREAM t=5, then a fresh job one cycle later.
      start_job(4, k);
      while (cyc - k < 2 + H + 5) step();
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_busy", busy, 1'b0);
      chk("abort_en_i", en_i, '0);
      step();
      start_job(3, k);
      d = -1;
      for (int i = 0; i < 200 && d < 0; i++) begin
         if (done === 1'b1) d = cyc - k;
         step();
      end
      chk("post_abort_done_at", 64'(d), 64'(2 + H + 3 + H + W - 1));
      step();

`ifdef ARRAY_CTRL_STALL_EN
      // Stall three cycles from t=2: en_i[0] reads 1,1,0,0,0,1,1.
      start_job(4, k);
      d = -1; pat = 0;
      for (int i = 0; i < 200 && d < 0; i++) begin
         o = cyc - k;
         stall = (o >= 2 + H + 2 && o < 2 + H + 5);
         if (o >= 2 + H && o < 2 + H + 7) pat = (pat << 1) | int'(en_i[0]);
         if (done === 1'b1) d = o;
         step();
      end
      stall = 1'b0;
      chk("stall_pattern", 64'(pat), 64'b1100011);
      chk("stall_done_at", 64'(d), 64'd46);
      step();
`endif

      // Asynchronous reset mid-STREAM.
      start_job(4, k);
      while (cyc - k < 2 + H + 3) step();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_outs", {busy, done, wght_rdy, ifm_rdy, ofm_vld, en_i, en_o, en_w}, '0);
      m_job = 0;
      @(negedge clk);
      rst_n = 1'b1;
      repeat (3) step();

      // Random traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         start = ($urandom % 6) == 0;
         n_vec = cnt_t'($urandom % 24);
         abort = ($urandom % 250) == 0;
`ifdef ARRAY_CTRL_STALL_EN
         stall = ($urandom % 5) == 0;
`endif
         step();
      end
      start = 1'b0; abort = 1'b0; stall = 1'b0;
      step();

      $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
      $finish;
   end

endmodule
